// File: rtl/uart_rx_word_asm_if.sv
// Byte-in / word-out bus of the UART word assembler.
// master = assembler side, slave = receiver/consumer side.
interface uart_rx_word_asm_if #(
    parameter int NBYTES = 4
);
    localparam int WORD_W = 8 * NBYTES;
    localparam int CNT_W  = $clog2(NBYTES) + 1;

    logic              rx_done_tick;
    logic [7:0]        din;
    logic              s_tick;
    logic              word_ready;
    logic              clear_overrun;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic [CNT_W-1:0]  byte_cnt;
    logic              overrun;
    logic              timeout_tick;

    modport master (
        input  rx_done_tick, din, s_tick, word_ready, clear_overrun,
        output word_out, word_valid, byte_cnt, overrun, timeout_tick
    );

    modport slave (
        output rx_done_tick, din, s_tick, word_ready, clear_overrun,
        input  word_out, word_valid, byte_cnt, overrun, timeout_tick
    );
endinterface

// File: rtl/uart_rx_word_asm.sv
// Packs NBYTES received bytes (LSB first) into a word; optional stale-partial discard via UART_RX_TIMEOUT_EN.
// Latency: word_valid rises on the edge sampling the last byte strobe (visible next cycle).
// Backpressure: one holding word plus one full assembly word; further bytes are dropped and flag overrun.
module uart_rx_word_asm #(
    parameter int NBYTES        = 4,
    parameter int TIMEOUT_TICKS = 640,
    parameter int TCNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_word_asm_if.master  bus
);
    localparam int WORD_W = 8 * NBYTES;
    localparam int CNT_W  = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBYTES);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] asm_q, asm_n, asm_ins;
    logic [WORD_W-1:0] hold_q, hold_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              vld_q, vld_n;
    logic              ovr_q, ovr_n;
    logic              take;

`ifdef UART_RX_TIMEOUT_EN
    logic [TCNT_W-1:0] tcnt_q, tcnt_n;
    logic              tmo_q, tmo_n;
`endif

    assign take = vld_q & bus.word_ready;

    // Assembly word with the incoming byte dropped into lane byte_cnt.
    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                asm_ins[8*k +: 8] = bus.din;
            end
        end
    end

    always_comb begin
        state_n = state;
        asm_n   = asm_q;
        hold_n  = hold_q;
        cnt_n   = cnt_q;
        vld_n   = vld_q & ~bus.word_ready;
        ovr_n   = ovr_q & ~bus.clear_overrun;
`ifdef UART_RX_TIMEOUT_EN
        tcnt_n  = '0;
        tmo_n   = 1'b0;
`endif
        case (state)
            EMPTY, COLLECT: begin
                if (bus.rx_done_tick) begin
                    if (cnt_q == LAST_IDX) begin
                        // Holding register free now or emptying this edge: hand over directly.
                        if (!vld_q || bus.word_ready) begin
                            hold_n  = asm_ins;
                            vld_n   = 1'b1;
                            asm_n   = '0;
                            cnt_n   = '0;
                            state_n = EMPTY;
                        end else begin
                            asm_n   = asm_ins;
                            cnt_n   = FULL_CNT;
                            state_n = STALL;
                        end
                    end else begin
                        asm_n   = asm_ins;
                        cnt_n   = cnt_q + CNT_W'(1);
                        state_n = COLLECT;
                    end
                end
`ifdef UART_RX_TIMEOUT_EN
                else if (state == COLLECT) begin
                    if (bus.s_tick) begin
                        if (tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
                            asm_n   = '0;
                            cnt_n   = '0;
                            state_n = EMPTY;
                            tmo_n   = 1'b1;
                        end else begin
                            tcnt_n = tcnt_q + TCNT_W'(1);
                        end
                    end else begin
                        tcnt_n = tcnt_q;
                    end
                end
`endif
            end
            STALL: begin
                if (take) begin
                    hold_n = asm_q;
                    vld_n  = 1'b1;
                    if (bus.rx_done_tick) begin
                        asm_n   = {{(WORD_W-8){1'b0}}, bus.din};
                        cnt_n   = CNT_W'(1);
                        state_n = COLLECT;
                    end else begin
                        asm_n   = '0;
                        cnt_n   = '0;
                        state_n = EMPTY;
                    end
                end else if (bus.rx_done_tick) begin
                    ovr_n = 1'b1;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            asm_q  <= '0;
            hold_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            asm_q  <= asm_n;
            hold_q <= hold_n;
            cnt_q  <= cnt_n;
            vld_q  <= vld_n;
            ovr_q  <= ovr_n;
`ifdef UART_RX_TIMEOUT_EN
            tcnt_q <= tcnt_n;
            tmo_q  <= tmo_n;
`endif
        end
    end

    assign bus.word_out   = hold_q;
    assign bus.word_valid = vld_q;
    assign bus.byte_cnt   = cnt_q;
    assign bus.overrun    = ovr_q;

`ifdef UART_RX_TIMEOUT_EN
    assign bus.timeout_tick = tmo_q;
`else
    localparam int unused_tmo_cfg = TIMEOUT_TICKS + TCNT_W;
    logic unused_s_tick;
    assign unused_s_tick    = bus.s_tick;
    assign bus.timeout_tick = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_word_asm.sv
// Directed bench for uart_rx_word_asm: queue-based word model checked every cycle plus literal spot checks.
module tb_uart_rx_word_asm;
    localparam int NB  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_rx_word_asm_if #(.NBYTES(NB)) bus ();

    uart_rx_word_asm #(
        .NBYTES       (NB),
        .TIMEOUT_TICKS(TMO),
        .TCNT_W       (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model: bytes in a queue, holding word, flags ----------------
    logic [7:0]  q[$];
    logic [31:0] m_word  = '0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_tmo   = 1'b0;
    int          m_idle  = 0;
    bit          m_rx, m_take, m_drop;

    function automatic logic [31:0] pack_q();
        logic [31:0] w = '0;
        for (int k = 0; k < NB; k++) w = w | (32'(q[k]) << (8 * k));
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_word = '0; m_valid = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0; m_idle = 0;
        end else begin
            m_rx   = bus.rx_done_tick;
            m_take = m_valid && bus.word_ready;
            m_drop = 1'b0;
            m_tmo  = 1'b0;
            if (m_take) m_valid = 1'b0;
            if (q.size() == NB) begin
                m_idle = 0;
                if (m_take) begin
                    m_word = pack_q(); m_valid = 1'b1; q.delete();
                    if (m_rx) q.push_back(bus.din);
                end else if (m_rx) begin
                    m_drop = 1'b1;
                end
            end else if (m_rx) begin
                q.push_back(bus.din);
                m_idle = 0;
                if (q.size() == NB && !m_valid) begin
                    m_word = pack_q(); m_valid = 1'b1; q.delete();
                end
            end else if (q.size() > 0) begin
`ifdef UART_RX_TIMEOUT_EN
                if (bus.s_tick) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        q.delete(); m_idle = 0; m_tmo = 1'b1;
                    end
                end
`endif
            end
            if (m_drop) m_ovr = 1'b1;
            else if (bus.clear_overrun) m_ovr = 1'b0;
        end
    end

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        expect_eq("m.word_out",     64'(bus.word_out),     64'(m_word));
        expect_eq("m.word_valid",   64'(bus.word_valid),   64'(m_valid));
        expect_eq("m.byte_cnt",     64'(bus.byte_cnt),     64'(q.size()));
        expect_eq("m.overrun",      64'(bus.overrun),      64'(m_ovr));
        expect_eq("m.timeout_tick", 64'(bus.timeout_tick), 64'(m_tmo));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit rx, input logic [7:0] d, input bit rdy, input bit clr, input bit st);
        bus.rx_done_tick  = rx;
        bus.din           = d;
        bus.word_ready    = rdy;
        bus.clear_overrun = clr;
        bus.s_tick        = st;
        @(negedge clk);
        bus.rx_done_tick  = 1'b0;
        bus.din           = 8'h00;
        bus.word_ready    = 1'b0;
        bus.clear_overrun = 1'b0;
        bus.s_tick        = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit rdy);
        cyc(1'b1, d, rdy, 1'b0, 1'b0);
    endtask

    task automatic send4(input logic [31:0] w, input bit rdy);
        logic [31:0] t = w;
        for (int k = 0; k < 4; k++) send(t[8*k +: 8], rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_done_tick = 1'b0; bus.din = 8'h00; bus.s_tick = 1'b0;
        bus.word_ready = 1'b0; bus.clear_overrun = 1'b0;
        repeat (2) @(negedge clk);
        expect_eq("rst.word_out", 64'(bus.word_out), 64'h0);
        expect_eq("rst.valid",    64'(bus.word_valid), 64'h0);
        expect_eq("rst.byte_cnt", 64'(bus.byte_cnt), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Straight-through word with consumer ready.
        send4(32'h44332211, 1'b1);
        expect_eq("t1.word",  64'(bus.word_out), 64'h44332211);
        expect_eq("t1.valid", 64'(bus.word_valid), 64'h1);
        expect_eq("t1.cnt",   64'(bus.byte_cnt), 64'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_eq("t1.valid_drop", 64'(bus.word_valid), 64'h0);

        // Holding full, second word stalls, then one handshake swaps it in.
        send4(32'hDDCCBBAA, 1'b0);
        send4(32'h04030201, 1'b0);
        expect_eq("t2.cnt_stall", 64'(bus.byte_cnt), 64'h4);
        expect_eq("t2.word_held", 64'(bus.word_out), 64'hDDCCBBAA);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_eq("t2.word_new",  64'(bus.word_out), 64'h04030201);
        expect_eq("t2.valid",     64'(bus.word_valid), 64'h1);
        expect_eq("t2.cnt",       64'(bus.byte_cnt), 64'h0);

        // Overrun: drop, clear, then set and clear together.
        send4(32'h40302010, 1'b0);
        send(8'h55, 1'b0);
        expect_eq("t3.ovr_set",   64'(bus.overrun), 64'h1);
        expect_eq("t3.word",      64'(bus.word_out), 64'h04030201);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_eq("t3.ovr_clr",   64'(bus.overrun), 64'h0);
        cyc(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        expect_eq("t3.set_wins",  64'(bus.overrun), 64'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Byte and handshake in the same STALL cycle.
        send(8'h99, 1'b1);
        expect_eq("t4.word",  64'(bus.word_out), 64'h40302010);
        expect_eq("t4.valid", 64'(bus.word_valid), 64'h1);
        expect_eq("t4.cnt",   64'(bus.byte_cnt), 64'h1);
        expect_eq("t4.ovr",   64'(bus.overrun), 64'h0);
        send(8'h88, 1'b1);
        send(8'h77, 1'b0);
        send(8'h66, 1'b0);
        expect_eq("t4.next_word", 64'(bus.word_out), 64'h66778899);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Stale partial word.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        repeat (TMO - 1) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_eq("t5.no_tmo_yet", 64'(bus.timeout_tick), 64'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_TIMEOUT_EN
        expect_eq("t5.tmo_pulse", 64'(bus.timeout_tick), 64'h1);
        expect_eq("t5.cnt",       64'(bus.byte_cnt), 64'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_eq("t5.tmo_low",   64'(bus.timeout_tick), 64'h0);
        send4(32'hA4A3A2A1, 1'b0);
        expect_eq("t5.word",      64'(bus.word_out), 64'hA4A3A2A1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Byte coinciding with the expiring tick wins.
        send(8'hB1, 1'b0);
        repeat (TMO - 1) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
        expect_eq("t5.byte_wins", 64'(bus.timeout_tick), 64'h0);
        expect_eq("t5.cnt2",      64'(bus.byte_cnt), 64'h2);
        repeat (TMO) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_eq("t5.tmo2",      64'(bus.timeout_tick), 64'h1);
`else
        expect_eq("t5.no_tmo",    64'(bus.timeout_tick), 64'h0);
        expect_eq("t5.cnt_kept",  64'(bus.byte_cnt), 64'h2);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        expect_eq("t5.word",      64'(bus.word_out), 64'hA2A1E2E1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

        // Async reset mid-word with a word pending.
        send4(32'hF4F3F2F1, 1'b0);
        send(8'h5A, 1'b0);
        send(8'h5B, 1'b0);
        expect_eq("t6.pre_cnt", 64'(bus.byte_cnt), 64'h2);
        #2 reset = 1'b1;
        #1;
        expect_eq("t6.rst_word",  64'(bus.word_out), 64'h0);
        expect_eq("t6.rst_valid", 64'(bus.word_valid), 64'h0);
        expect_eq("t6.rst_cnt",   64'(bus.byte_cnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        send4(32'hC4C3C2C1, 1'b0);
        expect_eq("t6.clean_word", 64'(bus.word_out), 64'hC4C3C2C1);
        expect_eq("t6.clean_cnt",  64'(bus.byte_cnt), 64'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        expect_eq("t6.drained", 64'(bus.word_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
